sonata_sw_debounce: RTL and testbench

- Conditions the raw Sonata board switch pins (user DIP switches and navigation joystick) before they reach the demo system's general-purpose input bus.
- Per bit: optional inversion of the active-low pin, a 2-flop synchroniser and a counter-based debouncer.
- Produces a clean level plus single-cycle rise/fall pulses for software-visible GPIO and interrupt logic.
- Sits between the top-level switch pads and the gp_i input of the demo system, in the clk_sys domain.

---
 rtl/sonata_sw_debounce.sv | 124 ++++++++++++
 tb/tb_sonata_sw_debounce.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sonata_sw_debounce.sv
// Switch conditioner: per-bit inversion, 2-flop synchroniser, counter debouncer, edge pulses.
// Latency: a pin level sampled at edge k reaches sw_o after edge k+1+DebounceCycles.
// No backpressure: free-running every clk_sys_i cycle, inputs never stalled.
//
// Ports:
//   clk_sys_i   system clock
//   rst_sys_ni  asynchronous active-low reset
//   sw_i        raw asynchronous switch pins (Width bits)
//   clr_i       per-bit pending-clear strobes
//   sw_o        debounced level, 1 = switch on
//   rise_o      one-cycle pulse when a sw_o bit goes 0->1
//   fall_o      one-cycle pulse when a sw_o bit goes 1->0
//   pending_o   latched edge flags (SONATA_SW_DEBOUNCE_IRQ_EN only, else 0)
//   irq_o       OR of pending flags (SONATA_SW_DEBOUNCE_IRQ_EN only, else 0)
//
// Optional feature macro: SONATA_SW_DEBOUNCE_IRQ_EN (pending flags + interrupt).

module sonata_sw_debounce #(
   parameter int unsigned Width          = 13,
   parameter int unsigned DebounceCycles = 500000,
   parameter bit          InvertInput    = 1'b1
) (
   input  logic             clk_sys_i,
   input  logic             rst_sys_ni,
   input  logic [Width-1:0] sw_i,
   input  logic [Width-1:0] clr_i,
   output logic [Width-1:0] sw_o,
   output logic [Width-1:0] rise_o,
   output logic [Width-1:0] fall_o,
   output logic [Width-1:0] pending_o,
   output logic             irq_o
);

   localparam int unsigned CntWidth = $clog2(DebounceCycles + 1);
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);
   localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

   logic [Width-1:0]    in_b;
   logic [Width-1:0]    s1_q, s2_q;
   logic [Width-1:0]    sw_q, sw_d;
   logic [Width-1:0]    rise_q, rise_d;
   logic [Width-1:0]    fall_q, fall_d;
   logic [CntWidth-1:0] cnt_q [Width];
   logic [CntWidth-1:0] cnt_d [Width];

   // Switches pull to ground when on, so the default inverts to get 1 = on.
   assign in_b = InvertInput ? ~sw_i : sw_i;

   // Each bit counts consecutive cycles where the synchronised level disagrees
   // with the accepted level; any agreeing cycle restarts the count. The final
   // disagreeing cycle accepts the level instead of incrementing, so the
   // counter tops out at DebounceCycles-1 and never wraps.
   always_comb begin
      sw_d   = sw_q;
      rise_d = '0;
      fall_d = '0;
      for (int b = 0; b < int'(Width); b++) begin
         cnt_d[b] = '0;
         if (s2_q[b] != sw_q[b]) begin
            if (cnt_q[b] == CntMax) begin
               sw_d[b]   = s2_q[b];
               rise_d[b] = s2_q[b];
               fall_d[b] = ~s2_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + CntOne;
            end
         end
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         s1_q   <= '0;
         s2_q   <= '0;
         sw_q   <= '0;
         rise_q <= '0;
         fall_q <= '0;
         for (int b = 0; b < int'(Width); b++) begin
            cnt_q[b] <= '0;
         end
      end else begin
         // Plain flop-to-flop synchroniser: nothing between s1 and s2.
         s1_q   <= in_b;
         s2_q   <= s1_q;
         sw_q   <= sw_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         for (int b = 0; b < int'(Width); b++) begin
            cnt_q[b] <= cnt_d[b];
         end
      end
   end

   assign sw_o   = sw_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

`ifdef SONATA_SW_DEBOUNCE_IRQ_EN
   logic [Width-1:0] pend_q, pend_d;
   logic             irq_q;

   // A new edge pulse wins over a clear strobe in the same cycle.
   assign pend_d = (pend_q & ~clr_i) | rise_q | fall_q;

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         pend_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         irq_q  <= |pend_d;
      end
   end

   assign pending_o = pend_q;
   assign irq_o     = irq_q;
`else
   logic unused_clr;
   assign unused_clr = ^clr_i;
   assign pending_o  = '0;
   assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_sonata_sw_debounce.sv
// Bench for sonata_sw_debounce: directed scenarios plus random pin activity,
// every cycle compared against a sliding-window reference model.
module tb_sonata_sw_debounce;

   localparam int W   = 13;
   localparam int D   = 4;
   localparam bit INV = 1'b1;

   logic         clk_sys = 1'b0;
   logic         rst_n;
   logic [W-1:0] sw;
   logic [W-1:0] clr;
   logic [W-1:0] sw_o, rise_o, fall_o, pending_o;
   logic         irq_o;

   sonata_sw_debounce #(
      .Width          (W),
      .DebounceCycles (D),
      .InvertInput    (INV)
   ) dut (
      .clk_sys_i  (clk_sys),
      .rst_sys_ni (rst_n),
      .sw_i       (sw),
      .clr_i      (clr),
      .sw_o       (sw_o),
      .rise_o     (rise_o),
      .fall_o     (fall_o),
      .pending_o  (pending_o),
      .irq_o      (irq_o)
   );

   always #5 clk_sys = ~clk_sys;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: a level is accepted once the last D synchronised
   // samples (pin value from two edges earlier) all disagree with it.
   logic [W-1:0] m_sw, m_rise, m_fall, m_pend;
   logic         m_irq;
   logic [W-1:0] hist[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [W-1:0] pin_on(input logic [W-1:0] p);
      return INV ? ~p : p;
   endfunction

   task automatic model_reset();
      m_sw   = '0;
      m_rise = '0;
      m_fall = '0;
      m_pend = '0;
      m_irq  = 1'b0;
      hist.delete();
      repeat (D + 2) hist.push_back('0);
   endtask

   task automatic model_step();
`ifdef SONATA_SW_DEBOUNCE_IRQ_EN
      m_pend = (m_pend & ~clr) | m_rise | m_fall;
      m_irq  = |m_pend;
`endif
      hist.push_back(pin_on(sw));
      hist.delete(0);
      for (int b = 0; b < W; b++) begin
         logic acc;
         acc = 1'b1;
         for (int i = 0; i < D; i++)
            if (hist[hist.size() - 3 - i][b] == m_sw[b]) acc = 1'b0;
         m_rise[b] = acc & ~m_sw[b];
         m_fall[b] = acc & m_sw[b];
         if (acc) m_sw[b] = ~m_sw[b];
      end
   endtask

   task automatic compare();
      chk("sw_o",      32'(sw_o),      32'(m_sw));
      chk("rise_o",    32'(rise_o),    32'(m_rise));
      chk("fall_o",    32'(fall_o),    32'(m_fall));
      chk("pending_o", 32'(pending_o), 32'(m_pend));
      chk("irq_o",     32'(irq_o),     32'(m_irq));
   endtask

   // One clock: edge, model update, check 1 ns later, return at the negedge
   // so the caller drives the next inputs away from the active edge.
   task automatic tick();
      @(posedge clk_sys);
      if (rst_n) model_step();
      #1 compare();
      @(negedge clk_sys);
   endtask

   // Counts clocks until the chosen pulse appears on bit b; expects D+2.
   task automatic wait_lat(input string tag, input int b, input bit want_rise);
      int n;
      for (n = 1; n <= 20; n++) begin
         tick();
         if ((want_rise ? rise_o[b] : fall_o[b]) == 1'b1) break;
      end
      chk(tag, 32'(n), 32'(D + 2));
   endtask

   initial begin
      rst_n = 1'b0;
      sw    = '1;
      clr   = '0;
      model_reset();
      #1 compare();
      @(negedge clk_sys);
      repeat (2) tick();
      rst_n = 1'b1;

      // Idle with all switches off.
      repeat (50) tick();
      chk("idle_sw", 32'(sw_o), 32'h0);

      // Switch 0 on: accepted D+2 clocks after the change.
      sw[0] = 1'b0;
      wait_lat("lat_rise0", 0, 1'b1);
      tick();

      // Short glitch on switch 3 must be rejected.
      sw[3] = 1'b0;
      repeat (3) tick();
      sw[3] = 1'b1;
      repeat (8) tick();
      chk("glitch_sw3", 32'(sw_o[3]), 32'h0);
      sw[3] = 1'b0;
      wait_lat("lat_rise3", 3, 1'b1);

      // Switch 5 on, then off: fall pulse D+2 clocks after release.
      sw[5] = 1'b0;
      repeat (10) tick();
      sw[5] = 1'b1;
      wait_lat("lat_fall5", 5, 1'b0);
      tick();
      chk("sw5_off", 32'(sw_o[5]), 32'h0);

      // Pending / interrupt handling.
      clr = '1;
      tick();
      clr = '0;
      sw[2] = 1'b0;
      wait_lat("lat_rise2", 2, 1'b1);
      tick();
`ifdef SONATA_SW_DEBOUNCE_IRQ_EN
      chk("pend_rise2", 32'(pending_o), 32'h004);
      chk("irq_rise2",  32'(irq_o),     32'h1);
`endif
      clr[2] = 1'b1;
      tick();
      clr[2] = 1'b0;
`ifdef SONATA_SW_DEBOUNCE_IRQ_EN
      chk("pend_clr2", 32'(pending_o), 32'h0);
      chk("irq_clr2",  32'(irq_o),     32'h0);
`endif
      sw[2] = 1'b1;
      wait_lat("lat_fall2", 2, 1'b0);
      clr[2] = 1'b1;
      tick();
      clr[2] = 1'b0;
`ifdef SONATA_SW_DEBOUNCE_IRQ_EN
      chk("pend_setwins", 32'(pending_o[2]), 32'h1);
`endif

      // Reset in the middle of a count with switch 7 on.
      sw[7] = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      model_reset();
      #1 compare();
      @(negedge clk_sys);
      repeat (2) tick();
      rst_n = 1'b1;
      wait_lat("lat_rst7", 7, 1'b1);
      chk("rst_sw0_back", 32'(sw_o[0]), 32'h1);

      // Random pin activity and clear strobes.
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < W; b++) begin
            if ($urandom_range(15) == 0) sw[b] = ~sw[b];
            clr[b] = ($urandom_range(7) == 0);
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
